disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_TICKS, default 4, giving the minimum scan ticks a grant is held before it can be rotated away (legal range 1..255).
REQ-002 The module SHALL have the following ports; reset is asynchronous and active-low.
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle scan strobe from the clock divider
- req0  input  1  requester 0 wants the display
- req1  input  1  requester 1 wants the display
- data0  input  16  requester 0 digits, nibble k drives digit k
- data1  input  16  requester 1 digits, nibble k drives digit k
- gnt0  output  1  display granted to requester 0
- gnt1  output  1  display granted to requester 1
- anode  output  4  active-low digit enable, at most one bit low
- nibble  output  4  hex value for the enabled digit, to the decoder
- blank  output  1  high when no requester holds the display

Function
REQ-003 The FSM SHALL have states IDLE, OWN0 and OWN1; gnt0=1 only in OWN0 and gnt1=1 only in OWN1; the grants are registered and never both high.
REQ-004 In IDLE, with exactly one req high, the FSM SHALL enter that requester's OWN state on the next clock edge.
REQ-005 In IDLE, with both req high, the FSM SHALL grant the requester not served most recently; after reset the last-served pointer selects requester 0 first.
REQ-006 In OWNx, if reqx is low, the FSM SHALL leave on the next edge: to the other OWN state if the other req is high, else to IDLE.
REQ-007 An 8-bit hold counter SHALL clear on every grant change and increment on each tick while in an OWN state, saturating at HOLD_TICKS.
REQ-008 In OWNx, with reqx high, the other req high and hold counter == HOLD_TICKS, the FSM SHALL switch to the other OWN state on the next edge (round-robin).
REQ-009 In OWNx, with reqx high and the other req low, the grant SHALL be held indefinitely.
REQ-010 A 2-bit digit counter SHALL advance by 1 on each tick, wrapping 3->0, and SHALL run regardless of FSM state.
REQ-011 anode SHALL be registered: ~(4'b0001 << digit) in OWN states, 4'b1111 in IDLE.
REQ-012 nibble SHALL be registered from the granted data bits [4*digit+3:4*digit], giving 1-cycle latency from a data change; in IDLE nibble SHALL be 4'h0.
REQ-013 blank SHALL be registered high in IDLE and low in OWN states, and SHALL be aligned with anode.
REQ-014 A tick coinciding with a grant change SHALL advance the digit counter but SHALL NOT increment the new owner's hold counter.
REQ-015 When tick is held high continuously, each clock SHALL count as one tick.

Reset
REQ-016 While reset_n is low, all outputs SHALL take their reset values immediately, independent of clock: state=IDLE, gnt0=gnt1=0, anode=4'b1111, nibble=4'h0, blank=1.
REQ-017 While reset_n is low, the internal counters SHALL be held as follows: digit=0, hold=0, last-served pointer=requester 1.
REQ-018 Reset asserted mid-grant SHALL drop the grant with no completion.
REQ-019 The first edge after reset_n rises SHALL evaluate REQ-004/005.

Configuration
REQ-020 With macro DISP_ARB_LOCK_EN defined, the module SHALL add input lock (1 bit).
REQ-021 With DISP_ARB_LOCK_EN defined, while lock is high, REQ-008 rotation SHALL be suppressed; REQ-006 release on a dropped req SHALL still apply.
REQ-022 With DISP_ARB_LOCK_EN undefined, the lock port SHALL be absent and behaviour SHALL be exactly REQ-003..019.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset, then req0=1 only, data0=16'h1234 -> gnt0=1 after 1 edge; over the next 4 ticks nibble cycles 4,3,2,1 with anode 1110,1101,1011,0111.
- Both req high from IDLE after reset -> gnt0 first; after 4 ticks gnt1=1, gnt0=0; after 4 more ticks gnt0=1 again.
- In OWN0, drop req0 with req1=0 -> next edge IDLE, anode=1111, blank=1, nibble=0.
- In OWN1 at hold=2, drop req1 with req0=1 -> gnt0=1 next edge, hold=0.
- HOLD_TICKS=1 with tick held high and both req high -> grant alternates every 2 cycles, never both high.
- DISP_ARB_LOCK_EN defined, lock=1, both req high -> gnt0 held for 20 ticks; lock=0 -> gnt1 on the next edge.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: arbitrates two requesters onto a 4-digit multiplexed display with hold-time round-robin.
// Optional feature macro DISP_ARB_LOCK_EN adds a lock input that suppresses rotation.
module disp_arbiter #(
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
`ifdef DISP_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  anode,
  output logic [3:0]  nibble,
  output logic        blank
);

  // Handshake: a requester holds reqx high for as long as it wants the display; gntx is the
  // registered grant, and dropping reqx releases the display on the next clock edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  hold;
  logic [1:0]  digit;
  logic        last_one;
  logic        hold_done;
  logic        lock_i;
  logic [3:0]  cur_nibble;

`ifdef DISP_ARB_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 1'b0;
`endif

  assign hold_done = (hold == HOLD_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // last_one=1 means requester 1 was served last, so a tie goes to requester 0.
        if (req0 && req1)  state_nxt = last_one ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                               state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_done && !lock_i)   state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                               state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_done && !lock_i)   state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_nibble = 4'h0;
    case (state)
      OWN0:    cur_nibble = data0[{digit, 2'b00} +: 4];
      OWN1:    cur_nibble = data1[{digit, 2'b00} +: 4];
      default: cur_nibble = 4'h0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      hold     <= 8'd0;
      digit    <= 2'd0;
      last_one <= 1'b1;
      anode    <= 4'b1111;
      nibble   <= 4'h0;
      blank    <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == OWN0);
      gnt1  <= (state_nxt == OWN1);
      // A grant change wins over a coincident tick so the new owner starts from zero.
      if (state_nxt != state)
        hold <= 8'd0;
      else if ((state != IDLE) && tick && (hold < HOLD_MAX))
        hold <= hold + 8'd1;
      if (tick)
        digit <= digit + 2'd1;
      if (state_nxt == OWN0)
        last_one <= 1'b0;
      else if (state_nxt == OWN1)
        last_one <= 1'b1;
      anode  <= (state == IDLE) ? 4'b1111 : ~(4'b0001 << digit);
      nibble <= cur_nibble;
      blank  <= (state == IDLE);
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: scoreboard bench for disp_arbiter, HOLD_TICKS=4 and HOLD_TICKS=1 side by side.
// Build with DISP_ARB_LOCK_EN defined to also exercise the lock input.
module tb_disp_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] data0 = 16'h0;
  logic [15:0] data1 = 16'h0;
  logic        lock = 1'b0;

  logic        gnt0_a, gnt1_a, blank_a;
  logic [3:0]  anode_a, nibble_a;
  logic        gnt0_b, gnt1_b, blank_b;
  logic [3:0]  anode_b, nibble_b;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  // model state, index 0 = HOLD_TICKS 4, index 1 = HOLD_TICKS 1
  int m_st[2];
  int m_hold[2];
  int m_dig[2];
  int m_last[2];
  int m_hmax[2] = '{4, 1};

  localparam logic [10:0] RESET_OUT = {1'b0, 1'b0, 4'b1111, 4'h0, 1'b1};

  disp_arbiter #(.HOLD_TICKS(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1),
`ifdef DISP_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt0(gnt0_a), .gnt1(gnt1_a), .anode(anode_a), .nibble(nibble_a), .blank(blank_a)
  );

  disp_arbiter #(.HOLD_TICKS(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1),
`ifdef DISP_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt0(gnt0_b), .gnt1(gnt1_b), .anode(anode_b), .nibble(nibble_b), .blank(blank_b)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] out_a();
    return {gnt0_a, gnt1_a, anode_a, nibble_a, blank_a};
  endfunction

  function automatic logic [10:0] out_b();
    return {gnt0_b, gnt1_b, anode_b, nibble_b, blank_b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_hold[i] = 0; m_dig[i] = 0; m_last[i] = 1;
    end
  endtask

  // Advances one model by one clock edge and pushes the outputs expected after that edge.
  task automatic model_edge(input int i);
    int nxt;
    logic own_r, oth_r;
    logic [3:0] one;
    logic [3:0] an, nb;
    logic [15:0] sh;
    logic bl;
    one = 4'b0001;
    if (m_st[i] == 0) begin
      an = 4'b1111; nb = 4'h0; bl = 1'b1;
    end else begin
      sh = (m_st[i] == 1) ? data0 : data1;
      sh = sh >> (4 * m_dig[i]);
      an = ~(one << m_dig[i]);
      nb = sh[3:0];
      bl = 1'b0;
    end
    if (m_st[i] == 0) begin
      if (req0 && req1)  nxt = (m_last[i] == 1) ? 1 : 2;
      else if (req0)     nxt = 1;
      else if (req1)     nxt = 2;
      else               nxt = 0;
    end else begin
      own_r = (m_st[i] == 1) ? req0 : req1;
      oth_r = (m_st[i] == 1) ? req1 : req0;
      if (!own_r)                                          nxt = oth_r ? 3 - m_st[i] : 0;
      else if (oth_r && m_hold[i] == m_hmax[i] && !lock)   nxt = 3 - m_st[i];
      else                                                 nxt = m_st[i];
    end
    if (nxt != m_st[i]) m_hold[i] = 0;
    else if (m_st[i] != 0 && tick && m_hold[i] < m_hmax[i]) m_hold[i]++;
    if (nxt != 0) m_last[i] = nxt - 1;
    if (tick) m_dig[i] = (m_dig[i] + 1) % 4;
    m_st[i] = nxt;
    exp_q.push_back({nxt == 1, nxt == 2, an, nb, bl});
  endtask

  // Drives inputs at the falling edge, models the next rising edge, compares at the following falling edge.
  task automatic step(input logic t, input logic r0, input logic r1);
    logic [10:0] e;
    tick = t; req0 = r0; req1 = r1;
    model_edge(0);
    model_edge(1);
    @(posedge clock);
    @(negedge clock);
    e = exp_q.pop_front();
    check("out_h4", 32'(out_a()), 32'(e));
    e = exp_q.pop_front();
    check("out_h1", 32'(out_b()), 32'(e));
    check("gnt_excl", 32'(gnt0_a & gnt1_a | gnt0_b & gnt1_b), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_h4", 32'(out_a()), 32'(RESET_OUT));
    check("rst_h1", 32'(out_b()), 32'(RESET_OUT));
    check("rst_q", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model_reset();
    tick = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [3:0] nib_tab[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] an_tab[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    model_reset();
    do_reset();

    // single requester, digit scan of 16'h1234
    data0 = 16'h1234; data1 = 16'hABCD;
    step(1'b0, 1'b1, 1'b0);
    check("s1_gnt0", 32'(gnt0_a), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check("s1_nibble", 32'(nibble_a), 32'(nib_tab[k]));
      check("s1_anode", 32'(anode_a), 32'(an_tab[k]));
    end

    // reset mid-grant drops the grant at once
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_gnt0", 32'(gnt0_a), 32'd0);
    check("midrst_blank", 32'(blank_a), 32'd1);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // both requesting from IDLE: requester 0 first, then rotation
    step(1'b0, 1'b1, 1'b1);
    check("s2_first", 32'({gnt0_a, gnt1_a}), 32'b10);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      check("s2_rot_h4", 32'(gnt1_a), 32'((k >= 5 && k <= 9) ? 1 : 0));
      check("s2_rot_h1", 32'(gnt1_b), 32'((k / 2) % 2));
    end

    // drop req0 with req1 low: IDLE, then blanked outputs
    step(1'b1, 1'b0, 1'b0);
    check("s3_gnt0", 32'(gnt0_a), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("s3_idle", 32'({anode_a, nibble_a, blank_a}), 32'({4'b1111, 4'h0, 1'b1}));

    // OWN1 at hold 2, hand over to requester 0
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("s4_gnt", 32'({gnt0_a, gnt1_a}), 32'b10);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b1);
      check("s4_hold0", 32'(gnt1_a), 32'(k == 5 ? 1 : 0));
    end

`ifdef DISP_ARB_LOCK_EN
    do_reset();
    lock = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b1);
      check("lock_hold", 32'(gnt0_a), 32'd1);
    end
    lock = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    check("lock_rel", 32'(gnt1_a), 32'd1);
`endif

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 300; k++) begin
      data0 = 16'($urandom_range(0, 65535));
      data1 = 16'($urandom_range(0, 65535));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
